// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// instruction width and default address-map parameters.
package fetch_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STALL,
        FLUSH,
        HALT
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [63:0] DEFAULT_RESET_PC  = 64'd0;
    localparam int unsigned DEFAULT_MEM_BYTES = 264;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage signal bundle between the hazard/execute logic (master)
// and the fetch controller (slave).
interface fetch_controller_if;

    logic        PC_write;
    logic        Branch_taken;
    logic [63:0] Branch_target;
    logic [63:0] Instr_Address;
    logic        IF_ID_write;
    logic        IF_flush;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        output PC_write, Branch_taken, Branch_target,
        input  Instr_Address, IF_ID_write, IF_flush, fetch_valid,
               halted, misalign_err, fetch_count
    );

    modport slave (
        input  PC_write, Branch_taken, Branch_target,
        output Instr_Address, IF_ID_write, IF_flush, fetch_valid,
               halted, misalign_err, fetch_count
    );

endinterface

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the fetch PC, handles stalls,
// branch redirects, end-of-memory halt and misaligned-target detection.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input logic               clk,
    input logic               reset,
    fetch_controller_if.slave bus
);

    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'(INSTR_BYTES);

    fetch_state_t state;
    logic [63:0]  pc;
    logic         if_flush_q;
    logic         fetch_valid_q;
    logic         halted_q;
    logic         misalign_q;
    logic         if_id_write;
    logic [64:0]  pc_next_wide;
    logic         advance_ok;
    logic         target_aligned;
    logic         target_in_range;
    logic [31:0]  count;

    // 65-bit increment so a PC near 2^64 cannot wrap back into the legal range.
    always_comb begin
        pc_next_wide    = {1'b0, pc} + 65'(INSTR_BYTES);
        advance_ok      = pc_next_wide <= {1'b0, LAST_PC};
        target_aligned  = is_word_aligned(bus.Branch_target[1:0]);
        target_in_range = bus.Branch_target <= LAST_PC;
        if_id_write     = !reset && ((state == RUN) || (state == STALL))
                          && bus.PC_write && !bus.Branch_taken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            if_flush_q    <= 1'b1;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            fetch_valid_q <= if_id_write;
            if_flush_q    <= 1'b0;
            case (state)
                IDLE: begin
                    pc    <= RESET_PC;
                    state <= RUN;
                end
                // STALL shares RUN's decision tree; with PC_write=1 it issues a
                // fetch of the held PC, so it must advance like a normal RUN cycle.
                RUN, STALL: begin
                    if (bus.Branch_taken) begin
                        if (!target_aligned) begin
                            misalign_q <= 1'b1;
                            halted_q   <= 1'b1;
                            state      <= HALT;
                        end else if (!target_in_range) begin
                            halted_q <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc         <= bus.Branch_target;
                            if_flush_q <= 1'b1;
                            state      <= FLUSH;
                        end
                    end else if (!bus.PC_write) begin
                        state <= STALL;
                    end else if (advance_ok) begin
                        pc    <= pc_next_wide[63:0];
                        state <= RUN;
                    end else begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_fetch_count (
        .clk  (clk),
        .reset(reset),
        .inc  (if_id_write),
        .count(count)
    );

    assign bus.Instr_Address = pc;
    assign bus.IF_ID_write   = if_id_write;
    assign bus.IF_flush      = if_flush_q;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.halted        = halted_q;
    assign bus.misalign_err  = misalign_q;
    assign bus.fetch_count   = count;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: each step pushes its expected
// outputs when driven and pops them once the clock edge has produced them.
module tb_fetch_controller;

    localparam logic [63:0] T_RESET_PC = 64'd0;
    localparam int unsigned T_MEM      = 264;

    logic clk;
    logic reset;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC (T_RESET_PC),
        .MEM_BYTES(T_MEM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        ifid;
        logic [63:0] addr;
        logic        flush;
        logic        fv;
        logic        halted;
        logic        mis;
        logic [31:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        r;
        logic        pw;
        logic        bt;
        logic [63:0] tgt;
        logic        ifid;
        logic [63:0] addr;
        logic        flush;
        logic        halted;
        logic        mis;
    } step_t;

    obs_t        sb[$];
    int unsigned exp_cnt = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    function automatic step_t mk(input logic pw, input logic bt, input logic [63:0] tgt,
                                 input logic ifid, input logic [63:0] addr,
                                 input logic flush, input logic halted, input logic mis);
        step_t s;
        s = '{1'b0, pw, bt, tgt, ifid, addr, flush, halted, mis};
        return s;
    endfunction

    function automatic step_t mk_rst(input logic pw, input logic bt, input logic [63:0] tgt);
        step_t s;
        s = '{1'b1, pw, bt, tgt, 1'b0, T_RESET_PC, 1'b1, 1'b0, 1'b0};
        return s;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("addr=%h ifid=%b flush=%b fv=%b halted=%b mis=%b cnt=%0d",
                         o.addr, o.ifid, o.flush, o.fv, o.halted, o.mis, o.cnt);
    endfunction

    // Drives one cycle and records the expected outputs; fetch_valid follows
    // the cycle's IF_ID_write and the count tallies expected fetches.
    task automatic apply(input step_t s, output obs_t got);
        reset             = s.r;
        bus.PC_write      = s.pw;
        bus.Branch_taken  = s.bt;
        bus.Branch_target = s.tgt;
        if (s.r) begin
            exp_cnt = 0;
            sb.push_back('{1'b0, T_RESET_PC, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        end else begin
            if (s.ifid) exp_cnt++;
            sb.push_back('{s.ifid, s.addr, s.flush, s.ifid, s.halted, s.mis, 32'(exp_cnt)});
        end
        #3;
        got.ifid = bus.IF_ID_write;
        @(posedge clk);
        #1;
        got.addr   = bus.Instr_Address;
        got.flush  = bus.IF_flush;
        got.fv     = bus.fetch_valid;
        got.halted = bus.halted;
        got.mis    = bus.misalign_err;
        got.cnt    = bus.fetch_count;
    endtask

    task automatic test_reset;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk_rst(1'b0, 1'b1, 64'h40));
        st.push_back(mk_rst(1'b1, 1'b1, 64'h44));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_sequential;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 4; k++)
            st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'(4 * k), 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL sequential step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_stall;
        step_t st[$];
        obs_t  got, want;
        for (int k = 0; k < 3; k++)
            st.push_back(mk(1'b0, 1'b0, 64'd0, 1'b0, 64'd16, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'd20, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'd24, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL stall step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_branch;
        step_t st[$];
        obs_t  got, want;
        for (int a = 28; a <= 72; a += 4)
            st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'(a), 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 64'h98, 1'b0, 64'h98, 1'b1, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 64'h10, 1'b0, 64'h98, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'h9C, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'hA0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL branch step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_branch_vs_stall;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk(1'b0, 1'b1, 64'h20, 1'b0, 64'h20, 1'b1, 1'b0, 1'b0));
        st.push_back(mk_rst(1'b1, 1'b1, 64'h80));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b0, 1'b0, 64'd0, 1'b0, 64'd4, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b0, 1'b1, 64'h40, 1'b0, 64'h40, 1'b1, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'h40, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL branch_vs_stall step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_misalign;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'h44, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 64'h9A, 1'b0, 64'h44, 1'b0, 1'b1, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'h44, 1'b0, 1'b1, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'h44, 1'b0, 1'b1, 1'b1));
        st.push_back(mk(1'b1, 1'b1, 64'h40, 1'b0, 64'h44, 1'b0, 1'b1, 1'b1));
        st.push_back(mk(1'b0, 1'b0, 64'd0, 1'b0, 64'h44, 1'b0, 1'b1, 1'b1));
        st.push_back(mk_rst(1'b1, 1'b0, 64'd0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL misalign step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_out_of_range;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk(1'b1, 1'b1, 64'h108, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk_rst(1'b1, 1'b0, 64'd0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk_rst(1'b1, 1'b0, 64'd0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 64'h104, 1'b0, 64'h104, 1'b1, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'h104, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'h104, 1'b0, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'h104, 1'b0, 1'b1, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL out_of_range step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_run_to_end;
        step_t st[$];
        obs_t  got, want;
        st.push_back(mk_rst(1'b1, 1'b0, 64'd0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0));
        for (int a = 4; a <= 260; a += 4)
            st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'(a), 1'b0, 1'b0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b1, 64'd260, 1'b0, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd260, 1'b0, 1'b1, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 64'd0, 1'b0, 64'd260, 1'b0, 1'b1, 1'b0));
        foreach (st[i]) begin
            apply(st[i], got);
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL run_to_end step %0d: got %s, required %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        bus.PC_write      = 1'b0;
        bus.Branch_taken  = 1'b0;
        bus.Branch_target = 64'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_vs_stall();
        test_misalign();
        test_out_of_range();
        test_run_to_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
